// File: rtl/branch_resolve_stage_pkg.sv
// Shared types for the branch resolve stage: branch kinds, ARM-style
// condition codes and the stage FSM state encoding.
package branch_resolve_stage_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_CBZ   = 2'b01,
        OP_CBNZ  = 2'b10,
        OP_BCOND = 2'b11
    } branch_op_e;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_EVAL     = 2'b01,
        ST_REDIRECT = 2'b10
    } brs_state_e;

endpackage

// File: rtl/branch_resolve_stage_cond_eval.sv
// Combinational condition-code check: does {N,Z,C,V} satisfy cond?
// Shared with conditional-select logic, so it has no clock or state.
module cond_eval
    import branch_resolve_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;
    logic base;

    assign {n, z, c, v} = nzcv;

    // cond[3:1] picks the predicate, cond[0] inverts it (except for AL/NV).
    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
    end

    assign pass = (cond[0] && (cond[3:1] != 3'b111)) ? ~base : base;

endmodule

// File: rtl/branch_resolve_stage.sv
// Branch resolve stage: captures one decoded branch, evaluates it for a
// cycle, and on a taken branch flushes younger work and redirects fetch.
module branch_resolve_stage
    import branch_resolve_stage_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_imm,
    input  logic [1:0]        in_op,
    input  logic [3:0]        in_cond,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [3:0]        in_nzcv,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic [ADDR_W-1:0] redir_pc,
    output logic              flush,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both 1. Once raised, redir_valid and redir_pc hold until that edge;
    // ready without valid (and in_valid while in_ready is 0) has no effect.

    brs_state_e        state;
    logic [ADDR_W-1:0] pc_q, imm_q, rt_q;
    branch_op_e        op_q;
    logic [3:0]        cond_q, nzcv_q;
    logic              cond_pass;
    logic              taken;
    logic [ADDR_W-1:0] target;

    cond_eval u_cond_eval (
        .cond (cond_q),
        .nzcv (nzcv_q),
        .pass (cond_pass)
    );

    assign target    = pc_q + imm_q;
    assign in_ready  = (state == ST_IDLE);
    assign dbg_state = state;

    always_comb begin
        taken = 1'b0;
        case (op_q)
            OP_CBZ:   taken = (rt_q == '0);
            OP_CBNZ:  taken = (rt_q != '0);
            OP_BCOND: taken = cond_pass;
            default:  taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pc_q        <= '0;
            imm_q       <= '0;
            rt_q        <= '0;
            op_q        <= OP_NONE;
            cond_q      <= '0;
            nzcv_q      <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            flush       <= 1'b0;
            branch_cnt  <= '0;
            taken_cnt   <= '0;
        end else begin
            flush <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        pc_q   <= in_pc;
                        imm_q  <= in_imm;
                        rt_q   <= in_rt;
                        op_q   <= branch_op_e'(in_op);
                        cond_q <= in_cond;
                        nzcv_q <= in_nzcv;
                        state  <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (op_q != OP_NONE) begin
                        branch_cnt <= branch_cnt + CNT_W'(1);
                    end
                    if (taken) begin
                        taken_cnt   <= taken_cnt + CNT_W'(1);
                        flush       <= 1'b1;
                        redir_valid <= 1'b1;
                        redir_pc    <= target;
                        state       <= ST_REDIRECT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed + randomized bench for branch_resolve_stage with a behavioural
// reference model of branch outcome, target and statistics counters.
module tb_branch_resolve_stage;
    import branch_resolve_stage_pkg::*;

    localparam int ADDR_W = 64;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc = '0;
    logic [ADDR_W-1:0] in_imm = '0;
    logic [1:0]        in_op = '0;
    logic [3:0]        in_cond = '0;
    logic [ADDR_W-1:0] in_rt = '0;
    logic [3:0]        in_nzcv = '0;
    logic              redir_valid;
    logic              redir_ready = 1'b0;
    logic [ADDR_W-1:0] redir_pc;
    logic              flush;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  taken_cnt;
    logic [1:0]        dbg_state;

    int tests = 0;
    int fails = 0;
    logic [CNT_W-1:0] exp_branch = '0;
    logic [CNT_W-1:0] exp_taken  = '0;

    branch_resolve_stage #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_imm      (in_imm),
        .in_op       (in_op),
        .in_cond     (in_cond),
        .in_rt       (in_rt),
        .in_nzcv     (in_nzcv),
        .redir_valid (redir_valid),
        .redir_ready (redir_ready),
        .redir_pc    (redir_pc),
        .flush       (flush),
        .branch_cnt  (branch_cnt),
        .taken_cnt   (taken_cnt),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of each branch kind and condition code.
    function automatic bit ref_taken(input logic [1:0] op, input logic [3:0] cond,
                                     input logic [63:0] rt, input logic [3:0] nzcv);
        bit n, z, c, v;
        {n, z, c, v} = nzcv;
        if (op == 2'b00) return 1'b0;
        if (op == 2'b01) return (rt == 64'd0);
        if (op == 2'b10) return (rt != 64'd0);
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        exp_branch = '0;
        exp_taken  = '0;
        check("rst_redir_valid", 64'(redir_valid), 64'd0);
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_redir_pc", redir_pc, 64'd0);
        check("rst_branch_cnt", 64'(branch_cnt), 64'd0);
        check("rst_taken_cnt", 64'(taken_cnt), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Present one branch in IDLE, then follow it through EVAL and REDIRECT,
    // keeping redir_ready low for `hold` cycles after the redirect appears.
    task automatic issue(input logic [1:0] op, input logic [3:0] cond, input logic [63:0] rt,
                         input logic [3:0] nzcv, input logic [63:0] pc, input logic [63:0] imm,
                         input int hold);
        bit          tk;
        logic [63:0] tgt;
        tk  = ref_taken(op, cond, rt, nzcv);
        tgt = pc + imm;
        check("pre_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op = op; in_cond = cond; in_rt = rt; in_nzcv = nzcv; in_pc = pc; in_imm = imm;
        @(posedge clk);
        @(negedge clk);
        check("eval_in_ready", 64'(in_ready), 64'd0);
        check("eval_state", 64'(dbg_state), 64'(ST_EVAL));
        // Junk on the input side must not disturb the held branch.
        in_valid = 1'($urandom_range(0, 1));
        in_pc = {$urandom, $urandom}; in_imm = {$urandom, $urandom}; in_rt = {$urandom, $urandom};
        in_op = 2'($urandom); in_nzcv = 4'($urandom);
        redir_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        if (op != 2'b00) exp_branch = exp_branch + 1;
        if (tk) exp_taken = exp_taken + 1;
        check("flush", 64'(flush), 64'(tk));
        check("redir_valid", 64'(redir_valid), 64'(tk));
        check("branch_cnt", 64'(branch_cnt), 64'(exp_branch));
        check("taken_cnt", 64'(taken_cnt), 64'(exp_taken));
        if (!tk) begin
            in_valid = 1'b0;
            check("nt_in_ready", 64'(in_ready), 64'd1);
            return;
        end
        check("redir_pc", redir_pc, tgt);
        check("redir_in_ready", 64'(in_ready), 64'd0);
        in_valid = (hold > 0);
        redir_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_redir_valid", 64'(redir_valid), 64'd1);
            check("hold_redir_pc", redir_pc, tgt);
            check("hold_flush", 64'(flush), 64'd0);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        redir_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        redir_ready = 1'($urandom_range(0, 1));
        check("done_redir_valid", 64'(redir_valid), 64'd0);
        check("done_flush", 64'(flush), 64'd0);
        check("done_in_ready", 64'(in_ready), 64'd1);
        check("done_branch_cnt", 64'(branch_cnt), 64'(exp_branch));
    endtask

    initial begin
        do_reset();
        // Taken CBZ with immediate acceptance.
        issue(2'b01, 4'd0, 64'd0, 4'b0000, 64'h1000, 64'h40, 0);
        // CBNZ on zero: not taken.
        do_reset();
        issue(2'b10, 4'd0, 64'd0, 4'b0000, 64'h1000, 64'h40, 0);
        // B.LT, backward offset: taken with N!=V, not taken with N==V.
        issue(2'b11, 4'b1011, 64'd7, 4'b1000, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF8, 0);
        issue(2'b11, 4'b1011, 64'd7, 4'b1001, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF8, 0);
        // Back-pressured redirect for five cycles.
        issue(2'b01, 4'd0, 64'd0, 4'b0000, 64'h3000, 64'h100, 5);
        // Target wraps around the address space.
        issue(2'b01, 4'd0, 64'd0, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 0);
        // op none: no counting, never taken.
        issue(2'b00, 4'b1110, 64'd0, 4'b0000, 64'h4000, 64'h10, 0);

        for (int t = 0; t < 60; t++) begin
            logic [63:0] rt;
            rt = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
            issue(2'($urandom), 4'($urandom), rt, 4'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
        end

        // Reset asserted while a redirect is pending.
        issue(2'b01, 4'd0, 64'd0, 4'b0000, 64'h5000, 64'h20, 0);
        in_valid = 1'b1;
        in_op = 2'b01; in_rt = 64'd0; in_pc = 64'h6000; in_imm = 64'h80;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        redir_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_redir_valid", 64'(redir_valid), 64'd1);
        check("pre_rst_state", 64'(dbg_state), 64'(ST_REDIRECT));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_redir_valid", 64'(redir_valid), 64'd0);
        check("async_branch_cnt", 64'(branch_cnt), 64'd0);
        check("async_taken_cnt", 64'(taken_cnt), 64'd0);
        check("async_redir_pc", redir_pc, 64'd0);
        check("async_state", 64'(dbg_state), 64'(ST_IDLE));
        exp_branch = '0;
        exp_taken  = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_redir_valid", 64'(redir_valid), 64'd0);
        issue(2'b11, 4'b1110, 64'd0, 4'b0000, 64'h7000, 64'h4, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
